// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibit, request-to-send, bit shifting on device clock, ACK check.
// Optional macro PS2_GLITCH_FILTER_EN adds an 8-sample stability filter on the synchronised PS/2 clock.
module ps2_host_tx #(
   parameter int INHIBIT_CYCLES = 10000,
   parameter int TIMEOUT_CYCLES = 2000000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] tx_data,
   input  logic       tx_start,
   output logic       tx_busy,
   output logic       tx_done,
   output logic       tx_error,
   input  logic       ps2_clk_in,
   input  logic       ps2_data_in,
   output logic       ps2_clk_low,
   output logic       ps2_data_low
);

   localparam int INH_W = $clog2(INHIBIT_CYCLES + 1);
   localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYCLES - 1);
   localparam logic [TO_W-1:0]  TO_LIMIT = TO_W'(TIMEOUT_CYCLES);

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_INHIBIT   = 3'd1,
      S_REQ       = 3'd2,
      S_SEND      = 3'd3,
      S_WAIT_ACK  = 3'd4,
      S_WAIT_IDLE = 3'd5,
      S_DONE      = 3'd6
   } state_t;

   function automatic logic odd_parity(input logic [7:0] d);
      return ~^d;
   endfunction

   logic clk_meta_r, clk_sync_r, data_meta_r, data_sync_r;
   logic clk_lvl_s, clk_last_r, fall_r;

   state_t           state_r, state_next;
   logic [INH_W-1:0] inh_cnt_r, inh_cnt_next;
   logic [TO_W-1:0]  to_cnt_r, to_cnt_next;
   logic [3:0]       edge_cnt_r, edge_cnt_next, edge_inc_s;
   logic [7:0]       shift_r, shift_next;
   logic             par_r, par_next;
   logic             err_flag_r, err_flag_next;
   logic             timeout_s;
   logic             clk_low_next, data_low_next, done_next, error_next, busy_next;

   // Two-flop synchronisers; bus idles high so reset to 1 to avoid a false edge.
   always_ff @(posedge clk) begin
      if (reset) begin
         clk_meta_r  <= 1'b1;
         clk_sync_r  <= 1'b1;
         data_meta_r <= 1'b1;
         data_sync_r <= 1'b1;
      end else begin
         clk_meta_r  <= ps2_clk_in;
         clk_sync_r  <= clk_meta_r;
         data_meta_r <= ps2_data_in;
         data_sync_r <= data_meta_r;
      end
   end

`ifdef PS2_GLITCH_FILTER_EN
   logic [2:0] filt_cnt_r;
   logic       clk_filt_r;

   // Level follows the synchronised clock only after 8 consecutive differing samples.
   always_ff @(posedge clk) begin
      if (reset) begin
         filt_cnt_r <= 3'd0;
         clk_filt_r <= 1'b1;
      end else if (clk_sync_r == clk_filt_r) begin
         filt_cnt_r <= 3'd0;
      end else if (filt_cnt_r == 3'd7) begin
         filt_cnt_r <= 3'd0;
         clk_filt_r <= clk_sync_r;
      end else begin
         filt_cnt_r <= filt_cnt_r + 3'd1;
      end
   end

   assign clk_lvl_s = clk_filt_r;
`else
   assign clk_lvl_s = clk_sync_r;
`endif

   // Registered falling-edge detect on the (optionally filtered) clock level.
   always_ff @(posedge clk) begin
      if (reset) begin
         clk_last_r <= 1'b1;
         fall_r     <= 1'b0;
      end else begin
         clk_last_r <= clk_lvl_s;
         fall_r     <= clk_last_r & ~clk_lvl_s;
      end
   end

   assign edge_inc_s = edge_cnt_r + 4'd1;
   assign timeout_s  = (to_cnt_r == TO_LIMIT);

   // Next-state logic; line drives are computed one cycle ahead so outputs stay registered.
   always_comb begin
      state_next    = state_r;
      inh_cnt_next  = inh_cnt_r;
      to_cnt_next   = to_cnt_r;
      edge_cnt_next = edge_cnt_r;
      shift_next    = shift_r;
      par_next      = par_r;
      err_flag_next = err_flag_r;
      data_low_next = data_low_r_hold();
      case (state_r)
         S_IDLE: begin
            data_low_next = 1'b0;
            if (tx_start) begin
               shift_next    = tx_data;
               par_next      = odd_parity(tx_data);
               err_flag_next = 1'b0;
               inh_cnt_next  = '0;
               state_next    = S_INHIBIT;
            end else begin
               state_next = S_IDLE;
            end
         end
         S_INHIBIT: begin
            if (inh_cnt_r == INH_LAST) begin
               data_low_next = 1'b1;
               state_next    = S_REQ;
            end else begin
               data_low_next = 1'b0;
               inh_cnt_next  = inh_cnt_r + INH_W'(1);
            end
         end
         S_REQ: begin
            data_low_next = 1'b1;
            edge_cnt_next = 4'd0;
            to_cnt_next   = '0;
            state_next    = S_SEND;
         end
         S_SEND: begin
            if (fall_r) begin
               to_cnt_next   = '0;
               edge_cnt_next = edge_inc_s;
               if (edge_inc_s <= 4'd8) begin
                  data_low_next = ~shift_r[0];
                  shift_next    = {1'b0, shift_r[7:1]};
               end else if (edge_inc_s == 4'd9) begin
                  data_low_next = ~par_r;
               end else begin
                  data_low_next = 1'b0;
                  state_next    = S_WAIT_ACK;
               end
            end else if (timeout_s) begin
               data_low_next = 1'b0;
               err_flag_next = 1'b1;
               state_next    = S_DONE;
            end else begin
               to_cnt_next = to_cnt_r + TO_W'(1);
            end
         end
         S_WAIT_ACK: begin
            data_low_next = 1'b0;
            if (fall_r) begin
               err_flag_next = data_sync_r;
               edge_cnt_next = edge_inc_s;
               to_cnt_next   = '0;
               state_next    = S_WAIT_IDLE;
            end else if (timeout_s) begin
               err_flag_next = 1'b1;
               state_next    = S_DONE;
            end else begin
               to_cnt_next = to_cnt_r + TO_W'(1);
            end
         end
         S_WAIT_IDLE: begin
            data_low_next = 1'b0;
            if (clk_lvl_s && data_sync_r) begin
               state_next = S_DONE;
            end else if (timeout_s) begin
               err_flag_next = 1'b1;
               state_next    = S_DONE;
            end else begin
               to_cnt_next = to_cnt_r + TO_W'(1);
            end
         end
         S_DONE: begin
            data_low_next = 1'b0;
            inh_cnt_next  = '0;
            to_cnt_next   = '0;
            edge_cnt_next = 4'd0;
            state_next    = S_IDLE;
         end
         default: begin
            data_low_next = 1'b0;
            state_next    = S_IDLE;
         end
      endcase
      clk_low_next = (state_next == S_INHIBIT) || (state_next == S_REQ);
      done_next    = (state_next == S_DONE);
      error_next   = (state_next == S_DONE) && err_flag_next;
      busy_next    = (state_next != S_IDLE);
   end

   function automatic logic data_low_r_hold();
      return ps2_data_low;
   endfunction

   // State, counters and registered outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r      <= S_IDLE;
         inh_cnt_r    <= '0;
         to_cnt_r     <= '0;
         edge_cnt_r   <= 4'd0;
         shift_r      <= 8'd0;
         par_r        <= 1'b0;
         err_flag_r   <= 1'b0;
         ps2_clk_low  <= 1'b0;
         ps2_data_low <= 1'b0;
         tx_done      <= 1'b0;
         tx_error     <= 1'b0;
         tx_busy      <= 1'b0;
      end else begin
         state_r      <= state_next;
         inh_cnt_r    <= inh_cnt_next;
         to_cnt_r     <= to_cnt_next;
         edge_cnt_r   <= edge_cnt_next;
         shift_r      <= shift_next;
         par_r        <= par_next;
         err_flag_r   <= err_flag_next;
         ps2_clk_low  <= clk_low_next;
         ps2_data_low <= data_low_next;
         tx_done      <= done_next;
         tx_error     <= error_next;
         tx_busy      <= busy_next;
      end
   end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: open-drain bus with a clocking device model, scoreboard queues for
// the byte the device captures and the error status reported with tx_done.
module tb_ps2_host_tx;

   logic       clk = 1'b0;
   logic       reset;
   logic [7:0] tx_data;
   logic       tx_start;
   logic       tx_busy, tx_done, tx_error;
   logic       ps2_clk_in, ps2_data_in;
   logic       ps2_clk_low, ps2_data_low;
   logic       dev_clk_low = 1'b0;
   logic       dev_data_low = 1'b0;

   int n_compared   = 0;
   int n_mismatched = 0;
   int done_cnt     = 0;
   int done_cyc     = 0;
   int cyc          = 0;

   logic [8:0] byte_q[$];
   logic       err_q[$];

   ps2_host_tx #(.INHIBIT_CYCLES(100), .TIMEOUT_CYCLES(5000)) dut (
      .clk(clk), .reset(reset), .tx_data(tx_data), .tx_start(tx_start),
      .tx_busy(tx_busy), .tx_done(tx_done), .tx_error(tx_error),
      .ps2_clk_in(ps2_clk_in), .ps2_data_in(ps2_data_in),
      .ps2_clk_low(ps2_clk_low), .ps2_data_low(ps2_data_low)
   );

   assign ps2_clk_in  = ~(ps2_clk_low | dev_clk_low);
   assign ps2_data_in = ~(ps2_data_low | dev_data_low);

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_compared++;
      if (got !== exp) begin
         n_mismatched++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Every tx_done pops one expected error status.
   always @(negedge clk) begin
      if (tx_done) begin
         done_cnt++;
         done_cyc = cyc;
         check_value("done_expected", err_q.size() != 0, 1);
         if (err_q.size() != 0) check_value("tx_error", tx_error, err_q.pop_front());
         check_value("lines_free", {ps2_clk_low, ps2_data_low}, 0);
      end
   end

   // mode 0: ACK, 1: no ACK, 2: stop after 4 edges, 3: reset during 6th data bit
   task automatic device(input int mode, output logic [7:0] b, output logic par, output logic stop);
      int t;
      b = 8'h00; par = 1'b0; stop = 1'b0; t = 0;
      while (!ps2_clk_in && t < 1000) begin @(negedge clk); t++; end
      check_value("start_bit", ps2_data_in, 0);
      repeat (20) @(negedge clk);
      for (int e = 1; e <= 11; e++) begin
         if (mode == 2 && e == 5) return;
         if (mode == 0 && e == 11) dev_data_low = 1'b1;
         dev_clk_low = 1'b1;
         if (mode == 3 && e == 6) begin
            repeat (10) @(negedge clk);
            reset = 1'b1;
            @(negedge clk);
            reset = 1'b0;
            check_value("rst_clk_low", ps2_clk_low, 0);
            check_value("rst_data_low", ps2_data_low, 0);
            check_value("rst_busy", tx_busy, 0);
            dev_clk_low = 1'b0;
            return;
         end
         repeat (20) @(negedge clk);
         dev_clk_low = 1'b0;
         @(negedge clk);
         if (e <= 8) b[e-1] = ps2_data_in;
         else if (e == 9) par = ps2_data_in;
         else if (e == 10) stop = ps2_data_in;
         repeat (19) @(negedge clk);
         dev_data_low = 1'b0;
      end
   endtask

   task automatic run_txn(input logic [7:0] d, input logic p, input int mode,
                          input logic exp_err, input bit second);
      int cnt, d0, t_ret;
      logic [7:0] b;
      logic par, stop;
      logic [8:0] exp;
      d0 = done_cnt;
      @(negedge clk);
      tx_data = d; tx_start = 1'b1;
      byte_q.push_back({p, d});
      err_q.push_back(exp_err);
      @(negedge clk);
      tx_start = 1'b0; tx_data = 8'h00;
      check_value("clk_low_lat", ps2_clk_low, 1);
      check_value("busy_set", tx_busy, 1);
      cnt = 0;
      while (ps2_clk_low && !ps2_data_low && cnt < 1000) begin
         cnt++;
         tx_start = second && (cnt == 10);
         tx_data  = (second && cnt == 10) ? 8'h01 : 8'h00;
         @(negedge clk);
      end
      tx_start = 1'b0;
      check_value("inhibit_len", cnt, 100);
      check_value("req_lines", {ps2_clk_low, ps2_data_low}, 2'b11);
      device(mode, b, par, stop);
      t_ret = cyc;
      exp = byte_q.pop_front();
      if (mode <= 1) begin
         check_value("byte", b, exp[7:0]);
         check_value("parity", par, exp[8]);
         check_value("stop", stop, 1);
      end
      if (mode == 3) begin
         repeat (50) @(negedge clk);
         check_value("no_done_rst", done_cnt - d0, 0);
         err_q.delete();
      end else begin
         cnt = 0;
         while (done_cnt == d0 && cnt < 8000) begin @(negedge clk); cnt++; end
         check_value("done_wait", cnt < 8000, 1);
         if (mode == 2) check_value("timeout_win", (done_cyc - t_ret >= 4940) && (done_cyc - t_ret <= 5010), 1);
         repeat (2) @(negedge clk);
         check_value("busy_clear", tx_busy, 0);
         repeat (second ? 300 : 20) @(negedge clk);
         check_value("one_done", done_cnt - d0, 1);
         check_value("idle_lines", {ps2_clk_low, ps2_data_low}, 0);
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1; tx_start = 1'b0; tx_data = 8'h00;
      repeat (5) @(negedge clk);
      check_value("rst_busy0", tx_busy, 0);
      check_value("rst_done0", tx_done, 0);
      check_value("rst_err0", tx_error, 0);
      check_value("rst_clk0", ps2_clk_low, 0);
      check_value("rst_data0", ps2_data_low, 0);
      reset = 1'b0;
      repeat (5) @(negedge clk);
      run_txn(8'hED, 1'b1, 0, 1'b0, 1'b0);
      run_txn(8'hF4, 1'b0, 0, 1'b0, 1'b0);
      run_txn(8'h00, 1'b1, 0, 1'b0, 1'b0);
      run_txn(8'hA5, 1'b1, 1, 1'b1, 1'b0);
      run_txn(8'h3C, 1'b1, 2, 1'b1, 1'b0);
      run_txn(8'h55, 1'b1, 0, 1'b0, 1'b1);
      run_txn(8'h81, 1'b1, 3, 1'b0, 1'b0);
      run_txn(8'hFF, 1'b1, 0, 1'b0, 1'b0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end

endmodule
